spi_reg_bank: RTL
=================

Name: spi_reg_bank

Overview:
- Downstream of the SPI slave. Consumes each completed 16-bit frame (data byte + address byte, qualified by the SPI rising-SS pulse).
- Writes tuner control registers; services read requests.
- For a read request, loads the requested register into data_to_pc/address_to_pc for the SPI slave's shift-out. Raises send_to_pc_request and holds it until acknowledge handshake or timeout.

Parameters:
- NUM_REGS, 16, writable control registers at addresses 0..NUM_REGS-1 (max 128)
- STATUS_BASE, 8'h80, first address of read-only status bytes
- NUM_STATUS, 4, number of read-only status bytes
- READ_REQ_ADDR, 8'hF0, frame address meaning "read request, data byte = target address"
- ACK_TIMEOUT, 255, CLK cycles to wait for acknowledge before dropping request (1..255)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-low
- FRAME_VALID  in  1  one-cycle pulse, frame complete (SPI RISING_SS)
- SPI_DATA  in  8  frame data byte
- SPI_ADDRESS  in  8  frame address byte
- STATUS_IN  in  NUM_STATUS*8  read-only status bytes; byte k at [8k+7:8k]
- acknowledge  in  2  host handshake: 00 wait, 01 accept, 10 retry, 11 abort
- REG_OUT  out  NUM_REGS*8  control registers, reg k at [8k+7:8k]
- WR_STROBE  out  1  one-cycle pulse per register write
- WR_ADDR  out  8  address of last write, valid with WR_STROBE
- data_to_pc  out  8  read-back data to SPI slave
- address_to_pc  out  8  read-back address to SPI slave
- send_to_pc_request  out  1  read-back data valid, awaiting acknowledge
- ERR_CNT  out  8  saturating error count

Behaviour:
- Reset (RST low, async): REG_OUT, WR_ADDR, data_to_pc, address_to_pc and ERR_CNT are 0. WR_STROBE and send_to_pc_request are 0. FSM is IDLE. Pending slot and timeout counter are cleared.
- Frame capture: FRAME_VALID sampled high latches {SPI_ADDRESS, SPI_DATA} into a one-deep pending slot.
  - If the slot is already full, the new frame is dropped and ERR_CNT increments.
- FSM states: IDLE, DECODE, LOAD, WAIT_ACK.
- IDLE: if the slot is full, pop the frame and go to DECODE.
  - A frame arriving in IDLE with an empty slot reaches DECODE 2 edges after FRAME_VALID.
- DECODE (1 cycle):
  - addr < NUM_REGS: register[addr] <= data. WR_STROBE=1 and WR_ADDR=addr in the following cycle. Then IDLE.
  - addr == READ_REQ_ADDR: target <= data; go to LOAD.
  - Any other addr, including status space: no write, ERR_CNT increments; go to IDLE.
- LOAD (1 cycle): address_to_pc <= target; send_to_pc_request <= 1; timeout counter cleared; go to WAIT_ACK. data_to_pc takes:
  - register[target] if target < NUM_REGS
  - STATUS_IN byte (target-STATUS_BASE) if target is in status range; sampled here
  - 8'hEE otherwise (unmapped), with no error count
- WAIT_ACK: send_to_pc_request held at 1; data_to_pc and address_to_pc stable.
  - acknowledge 01: request <= 0, go to IDLE.
  - acknowledge 11: request <= 0, go to IDLE.
  - acknowledge 10: request <= 0, go to LOAD (fresh re-sample of status).
  - acknowledge 00: counter increments. When the counter reaches ACK_TIMEOUT: request <= 0, ERR_CNT increments, go to IDLE.
  - An acknowledge code other than 00 in the same cycle as timeout wins; no error count.
- acknowledge is ignored outside WAIT_ACK.
- Frames arriving in DECODE, LOAD or WAIT_ACK wait in the slot. Ordering is strictly FIFO.
- A register write does not alter an in-flight data_to_pc; data is latched at LOAD.
- ERR_CNT saturates at 255 with no wrap. Simultaneous error sources in one cycle count once.
- Addresses are compared as full 8 bits, unsigned.

Decomposition:
- Shared defines/package holds:
  - READ_REQ_ADDR default
  - ACK_WAIT/ACK_ACCEPT/ACK_RETRY/ACK_ABORT codes
  - UNMAPPED_DATA = 8'hEE
  - FSM state encoding
- One sub-module: spi_frame_slot, the one-deep holding buffer with push/pop/full and drop flag.
- The ACK_TIMEOUT counter stays inline.

Test Plan:
- Reset, then frame addr 8'h03 data 8'h5A -> REG_OUT[31:24]=8'h5A, WR_STROBE one pulse with WR_ADDR=8'h03, ERR_CNT=0.
- Write reg 2 = 8'hC3, then frame addr 8'hF0 data 8'h02 -> send_to_pc_request=1, data_to_pc=8'hC3, address_to_pc=8'h02. Held stable until acknowledge=01, then deasserted next edge.
- STATUS_IN byte1=8'h77, read request data 8'h81, acknowledge=10 while STATUS_IN byte1 changes to 8'h78 -> reload shows 8'h78. acknowledge=01 releases.
- Read request with acknowledge held 00 -> request drops exactly ACK_TIMEOUT cycles after WAIT_ACK entry, ERR_CNT=1. Read of 8'h40 returns 8'hEE with no error.
- During WAIT_ACK send write frames 8'h01 then 8'h04 -> first held in slot; second dropped with ERR_CNT+1. After accept, only reg 1 is written.
- Write to 8'h80 -> no REG_OUT change, ERR_CNT+1. Force 300 errors -> ERR_CNT=255. Assert RST mid WAIT_ACK -> all outputs 0 immediately.

Source files
------------

// File: rtl/spi_reg_bank_pkg.sv
// Shared types and constants for the SPI register bank: frame layout,
// acknowledge codes, sequencer state encoding and the saturating counter helper.
package spi_reg_bank_pkg;

    localparam logic [7:0] READ_REQ_ADDR_DEF = 8'hF0;
    localparam logic [7:0] STATUS_BASE_DEF   = 8'h80;
    localparam logic [7:0] UNMAPPED_DATA     = 8'hEE;

    localparam logic [1:0] ACK_WAIT   = 2'b00;
    localparam logic [1:0] ACK_ACCEPT = 2'b01;
    localparam logic [1:0] ACK_RETRY  = 2'b10;
    localparam logic [1:0] ACK_ABORT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_LOAD     = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } frame_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_reg_bank_slot.sv
// One-deep holding buffer for completed SPI frames. A push into a full slot
// is refused and flagged, unless the slot is being emptied in the same cycle.
module spi_frame_slot
    import spi_reg_bank_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   push,
    input  frame_t push_frame,
    input  logic   pop,
    output logic   full,
    output frame_t frame,
    output logic   drop
);

    logic   full_q, full_d;
    frame_t frame_q, frame_d;

    always_comb begin
        full_d  = full_q;
        frame_d = frame_q;
        drop    = 1'b0;
        if (pop) begin
            full_d = 1'b0;
        end
        if (push) begin
            if (full_q && !pop) begin
                drop = 1'b1;
            end else begin
                full_d  = 1'b1;
                frame_d = push_frame;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_q  <= 1'b0;
            frame_q <= '0;
        end else begin
            full_q  <= full_d;
            frame_q <= frame_d;
        end
    end

    assign full  = full_q;
    assign frame = frame_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Control register bank behind the SPI slave: applies write frames to the
// tuner registers and serves read requests through the acknowledge handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a frame in the slot; pops it when present
// DECODE    | classify popped frame: register write, read request, error
// LOAD      | latch read-back data/address, raise send_to_pc_request
// WAIT_ACK  | hold request until accept/abort/retry or timeout
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int         NUM_REGS      = 16,
    parameter logic [7:0] STATUS_BASE   = STATUS_BASE_DEF,
    parameter int         NUM_STATUS    = 4,
    parameter logic [7:0] READ_REQ_ADDR = READ_REQ_ADDR_DEF,
    parameter int         ACK_TIMEOUT   = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FRAME_VALID,
    input  logic [7:0]              SPI_DATA,
    input  logic [7:0]              SPI_ADDRESS,
    input  logic [NUM_STATUS*8-1:0] STATUS_IN,
    input  logic [1:0]              acknowledge,
    output logic [NUM_REGS*8-1:0]   REG_OUT,
    output logic                    WR_STROBE,
    output logic [7:0]              WR_ADDR,
    output logic [7:0]              data_to_pc,
    output logic [7:0]              address_to_pc,
    output logic                    send_to_pc_request,
    output logic [7:0]              ERR_CNT
);

    localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] REGS_END   = 9'(NUM_REGS);
    localparam logic [8:0] STATUS_END = 9'(int'(STATUS_BASE) + NUM_STATUS);
    localparam logic [7:0] TIMEOUT_TC = 8'(ACK_TIMEOUT);

    state_t     state_q, state_d;
    frame_t     frame_q, frame_d;
    logic [7:0] target_q, target_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req_q, req_d;
    logic [7:0] data_pc_q, data_pc_d;
    logic [7:0] addr_pc_q, addr_pc_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] err_q, err_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];

    logic       slot_full, slot_drop, slot_pop;
    frame_t     slot_frame;
    logic       err_inc;
    logic [7:0] load_data;
    logic [7:0] st_off;

    assign slot_pop = (state_q == ST_IDLE) && slot_full;

    spi_frame_slot u_slot (
        .CLK        (CLK),
        .RST        (RST),
        .push       (FRAME_VALID),
        .push_frame ({SPI_ADDRESS, SPI_DATA}),
        .pop        (slot_pop),
        .full       (slot_full),
        .frame      (slot_frame),
        .drop       (slot_drop)
    );

    // Read-back source selection; status bytes are sampled live at LOAD.
    always_comb begin
        load_data = UNMAPPED_DATA;
        st_off    = target_q - STATUS_BASE;
        if ({1'b0, target_q} < REGS_END) begin
            load_data = regs_q[target_q[IDX_W-1:0]];
        end else if (target_q >= STATUS_BASE && {1'b0, target_q} < STATUS_END) begin
            for (int k = 0; k < NUM_STATUS; k++) begin
                if (st_off == 8'(k)) begin
                    load_data = STATUS_IN[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        data_pc_d   = data_pc_q;
        addr_pc_d   = addr_pc_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        regs_d      = regs_q;
        err_inc     = slot_drop;

        case (state_q)
            ST_IDLE: begin
                if (slot_full) begin
                    frame_d = slot_frame;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if ({1'b0, frame_q.addr} < REGS_END) begin
                    regs_d[frame_q.addr[IDX_W-1:0]] = frame_q.data;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = frame_q.addr;
                    state_d     = ST_IDLE;
                end else if (frame_q.addr == READ_REQ_ADDR) begin
                    target_d = frame_q.data;
                    state_d  = ST_LOAD;
                end else begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                addr_pc_d = target_q;
                data_pc_d = load_data;
                req_d     = 1'b1;
                cnt_d     = 8'd0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                case (acknowledge)
                    ACK_ACCEPT, ACK_ABORT: begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                    ACK_RETRY: begin
                        req_d   = 1'b0;
                        state_d = ST_LOAD;
                    end
                    default: begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == TIMEOUT_TC) begin
                            req_d   = 1'b0;
                            err_inc = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = err_inc ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            data_pc_q   <= '0;
            addr_pc_q   <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            data_pc_q   <= data_pc_d;
            addr_pc_q   <= addr_pc_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign REG_OUT[g*8 +: 8] = regs_q[g];
    end

    assign WR_STROBE          = wr_strobe_q;
    assign WR_ADDR            = wr_addr_q;
    assign data_to_pc         = data_pc_q;
    assign address_to_pc      = addr_pc_q;
    assign send_to_pc_request = req_q;
    assign ERR_CNT            = err_q;

endmodule
